// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC owner and single-outstanding instruction fetcher
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] npc_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] instret_o,
  output logic        err_o,
  output logic        err_cause_o
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [31:0]   pc_q;
  logic [31:0]   inst_q;
  logic [31:0]   inst_pc_q;
  logic [31:0]   instret_q;
  logic [CW-1:0] wait_cnt_q;
  logic          err_cause_q;

  logic accept;
  logic npc_misaligned;
  logic rdata_take;
  logic timeout_hit;

  assign accept         = (state_q == ST_VALID) && inst_ready_i;
  assign npc_misaligned = |npc_i[1:0];
  // rvalid only counts in WAIT, which is never the grant cycle, so a same-cycle gnt/rvalid drops the rvalid.
  assign rdata_take     = (state_q == ST_WAIT) && imem_rvalid_i;
  assign timeout_hit    = (state_q == ST_WAIT) && !imem_rvalid_i && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (imem_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rdata_take)       state_d = ST_VALID;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_VALID: begin
        if (accept) state_d = npc_misaligned ? ST_ERR : ST_REQ;
      end
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      inst_pc_q   <= 32'h0;
      instret_q   <= 32'h0;
      wait_cnt_q  <= '0;
      err_cause_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == ST_REQ) && imem_gnt_i) begin
        wait_cnt_q <= '0;
      end else if ((state_q == ST_WAIT) && !imem_rvalid_i && !timeout_hit) begin
        wait_cnt_q <= wait_cnt_q + CW'(1);
      end

      if (rdata_take) begin
        inst_q    <= imem_rdata_i;
        inst_pc_q <= pc_q;
      end

      if (timeout_hit) err_cause_q <= 1'b1;

      // A misaligned target still retires the instruction that produced it; only the PC stays put.
      if (accept) begin
        instret_q <= instret_q + 32'd1;
        if (npc_misaligned) err_cause_q <= 1'b0;
        else                pc_q        <= npc_i;
      end
    end
  end

  assign pc_o         = pc_q;
  assign imem_req_o   = (state_q == ST_REQ);
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = (state_q == ST_VALID);
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign instret_o    = instret_q;
  assign err_o        = (state_q == ST_ERR);
  assign err_cause_o  = err_cause_q;

endmodule
